// File: rtl/ex_muldiv_unit_pkg.sv
// Shared control types for the RV32M iterative multiply/divide unit.
package ex_muldiv_unit_pkg;

   localparam int XLEN           = 32;
   localparam int MULDIV_LATENCY = XLEN + 2;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_t;

   // The upper encoding bit separates the divide family from the multiply family.
   function automatic logic is_div_op(input muldiv_op_t op);
      return op[2];
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface ex_muldiv_unit_if
   import ex_muldiv_unit_pkg::*;
();
   logic             start;
   logic             flush;
   muldiv_op_t       op;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic             stall;
   logic             done;
   logic [XLEN-1:0]  result;

   modport master (output start, flush, op, op_a, op_b,
                   input  stall, done, result);
   modport slave  (input  start, flush, op, op_a, op_b,
                   output stall, done, result);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed XLEN+2 cycle latency, one shared
// 2*XLEN shift register serving as product accumulator or remainder/quotient pair.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   ex_muldiv_unit_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

   state_t                 state_q;
   logic [XLEN-1:0]        count_q;
   logic [XLEN-1:0]        result_q, result_d;
   logic                   done_q;

   muldiv_op_t             op_q;
   logic [2*XLEN-1:0]      acc_q, acc_d;
   logic [XLEN-1:0]        b_mag_q;
   logic                   a_neg_q, b_neg_q, b_zero_q, ovf_q;

   logic                   accept;
   logic                   a_signed, b_signed, a_neg_d, b_neg_d;
   logic [XLEN-1:0]        a_mag_d, b_mag_d;

   logic [XLEN:0]          b_ext, mul_hi, trial;
   logic [XLEN-1:0]        rem_nx;
   logic                   ge;

   logic [2*XLEN-1:0]      prod;
   logic [XLEN-1:0]        quot, rem;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v);
      return ~v + (2*XLEN)'(1);
   endfunction

   assign accept     = (state_q == IDLE) & bus.start & ~bus.flush;
   assign bus.stall  = accept | (state_q == CALC) | (state_q == FIN);
   assign bus.done   = done_q;
   assign bus.result = result_q;

   // Classify operands at issue: signedness comes from the opcode, not the data.
   always_comb begin
      a_signed = (bus.op == MULH) || (bus.op == MULHSU) || (bus.op == DIV) || (bus.op == REM);
      b_signed = (bus.op == MULH) || (bus.op == DIV) || (bus.op == REM);
      a_neg_d  = a_signed & bus.op_a[XLEN-1];
      b_neg_d  = b_signed & bus.op_b[XLEN-1];
      a_mag_d  = a_neg_d ? neg_w(bus.op_a) : bus.op_a;
      b_mag_d  = b_neg_d ? neg_w(bus.op_b) : bus.op_b;
   end

   // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      b_ext  = {1'b0, b_mag_q};
      mul_hi = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? b_ext : '0);
      trial  = acc_q[2*XLEN-1:XLEN-1];
      ge     = (trial >= b_ext);
      rem_nx = ge ? XLEN'(trial - b_ext) : trial[XLEN-1:0];
      if (is_div_op(op_q))
         acc_d = {rem_nx, acc_q[XLEN-2:0], ge};
      else
         acc_d = {mul_hi, acc_q[XLEN-1:1]};
   end

   // Final sign correction and special-case selection. With a zero divisor the
   // restoring loop leaves |op_a| as remainder, so sign correction yields op_a.
   always_comb begin
      prod     = (a_neg_q ^ b_neg_q) ? neg_2w(acc_q) : acc_q;
      quot     = (a_neg_q ^ b_neg_q) ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      rem      = a_neg_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      result_d = result_q;
      case (op_q)
         MUL:                 result_d = prod[XLEN-1:0];
         MULH, MULHSU, MULHU: result_d = prod[2*XLEN-1:XLEN];
         DIV, DIVU:           result_d = b_zero_q ? '1 : (ovf_q ? INT_MIN : quot);
         REM, REMU:           result_d = b_zero_q ? rem : (ovf_q ? '0 : rem);
      endcase
   end

   // Operand datapath: loaded on accept, stepped every CALC cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q     <= bus.op;
         acc_q    <= {{XLEN{1'b0}}, a_mag_d};
         b_mag_q  <= b_mag_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= (bus.op_b == '0);
         ovf_q    <= ((bus.op == DIV) || (bus.op == REM)) &&
                     (bus.op_a == INT_MIN) && (bus.op_b == '1);
      end else if (state_q == CALC) begin
         acc_q    <= acc_d;
      end
   end

   // Control FSM: sequencing, iteration count, result register and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CALC;
                  count_q <= '0;
               end
            end
            CALC: begin
               if (bus.flush) begin
                  state_q <= IDLE;
                  count_q <= '0;
               end else if (count_q == XLEN'(XLEN - 1)) begin
                  state_q <= FIN;
                  count_q <= '0;
               end else begin
                  count_q <= count_q + XLEN'(1);
               end
            end
            FIN: begin
               if (bus.flush) begin
                  state_q <= IDLE;
               end else begin
                  result_q <= result_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, timing, flush,
// reset and randomized operations against an arithmetic reference model.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_muldiv_unit_if bus();

   ex_muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference result from the RV32M rules using wide integer arithmetic.
   function automatic logic [31:0] ref_result(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MUL:    begin p = sa * sb; return p[31:0]; end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Drives one instruction starting in the next cycle (cycle 0) and observes
   // cycles 0..ncyc-1. Optionally holds start (as a stalled ID/EX would) and
   // asserts flush in cycle flush_at.
   task automatic do_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int ncyc, input int flush_at, input bit hold,
                        output logic [31:0] res, output int done_cyc,
                        output int n_done, output int stall_low);
      done_cyc  = -1;
      n_done    = 0;
      stall_low = -1;
      res       = 'x;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            bus.start = 1'b1;
            bus.op    = op;
            bus.op_a  = a;
            bus.op_b  = b;
         end else begin
            bus.start = hold && (flush_at < 0 || k < flush_at);
         end
         if (k == flush_at) begin
            bus.flush = 1'b1;
            bus.start = 1'b0;
         end else begin
            bus.flush = 1'b0;
         end
         @(negedge clk);
         if (bus.stall !== 1'b1 && stall_low < 0) stall_low = k;
         if (bus.done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = k;
               res      = bus.result;
            end
         end
      end
      if (done_cyc < 0) res = bus.result;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         bus.flush = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = MUL;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_mul_timing();
      logic [31:0] res;
      int dc, nd, sl;
      do_op(MUL, 32'd7, 32'hFFFF_FFFD, MULDIV_LATENCY + 1, -1, 1'b0, res, dc, nd, sl);
      n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected %h", res, 32'hFFFF_FFEB); end
      n_checks++; if (dc !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mul_done_cycle: got %0d expected %0d", dc, MULDIV_LATENCY); end
      n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL mul_done_count: got %0d expected 1", nd); end
      n_checks++; if (sl !== MULDIV_LATENCY) begin n_fail++; $display("FAIL mul_stall_low: got %0d expected %0d", sl, MULDIV_LATENCY); end
      idle(1);
   endtask

   task automatic test_directed();
      muldiv_op_t  ops [10] = '{MULH, MULHU, MULHSU, DIV, REM, DIVU, DIV, REM, DIV, REM};
      logic [31:0] as  [10] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [10] = '{32'h8000_0000, 32'h8000_0000, 32'd2, 32'd2, 32'd2,
                                32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex  [10] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0};
      logic [31:0] res;
      int dc, nd, sl;
      for (int i = 0; i < 10; i++) begin
         do_op(ops[i], as[i], bs[i], MULDIV_LATENCY + 1, -1, bit'(i % 2), res, dc, nd, sl);
         n_checks++; if (res !== ex[i]) begin n_fail++; $display("FAIL directed_%0d_%s: got %h expected %h", i, ops[i].name(), res, ex[i]); end
         n_checks++; if (dc !== MULDIV_LATENCY || nd !== 1) begin n_fail++; $display("FAIL directed_%0d_timing: done cycle %0d count %0d expected cycle %0d count 1", i, dc, nd, MULDIV_LATENCY); end
      end
      idle(1);
   endtask

   task automatic test_flush();
      logic [31:0] res, prev;
      int dc, nd, sl;
      prev = bus.result;
      do_op(DIV, 32'd1000, 32'd7, 12, 10, 1'b1, res, dc, nd, sl);
      n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", nd); end
      n_checks++; if (sl !== 11) begin n_fail++; $display("FAIL flush_stall_low: got cycle %0d expected 11", sl); end
      n_checks++; if (res !== prev) begin n_fail++; $display("FAIL flush_result_hold: got %h expected %h", res, prev); end
      do_op(MUL, 32'd7, 32'hFFFF_FFFD, MULDIV_LATENCY + 1, -1, 1'b1, res, dc, nd, sl);
      n_checks++; if (dc + 12 !== 46) begin n_fail++; $display("FAIL flush_next_done: got cycle %0d expected 46", dc + 12); end
      n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL flush_next_result: got %h expected %h", res, 32'hFFFF_FFEB); end
      idle(1);
   endtask

   task automatic test_random();
      logic [31:0] res, a, b, exp;
      muldiv_op_t  op;
      int dc, nd, sl;
      for (int i = 0; i < 30; i++) begin
         op  = muldiv_op_t'($urandom_range(0, 7));
         a   = pick_operand();
         b   = pick_operand();
         exp = ref_result(op, a, b);
         do_op(op, a, b, MULDIV_LATENCY + 1, -1, bit'($urandom_range(0, 1)), res, dc, nd, sl);
         n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random_%0d_%s a=%h b=%h: got %h expected %h", i, op.name(), a, b, res, exp); end
         n_checks++; if (dc !== MULDIV_LATENCY || sl !== MULDIV_LATENCY) begin n_fail++; $display("FAIL random_%0d_timing: done cycle %0d stall low %0d expected %0d", i, dc, sl, MULDIV_LATENCY); end
      end
      idle(1);
   endtask

   task automatic test_back_to_back_after_reset();
      logic [31:0] res1, res2;
      int dc1, dc2, nd, sl;
      do_op(MUL, 32'd12345, 32'd678, 20, -1, 1'b1, res1, dc1, nd, sl);
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      #1;
      n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected %h", bus.result, 32'h0); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b expected 0", bus.stall); end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(MUL, 32'hFFFF_FFF0, 32'd3, MULDIV_LATENCY + 1, -1, 1'b1, res1, dc1, nd, sl);
      do_op(DIV, 32'hFFFF_FF9C, 32'd7, MULDIV_LATENCY + 1, -1, 1'b1, res2, dc2, nd, sl);
      n_checks++; if (res1 !== 32'hFFFF_FFD0) begin n_fail++; $display("FAIL b2b_mul_result: got %h expected %h", res1, 32'hFFFF_FFD0); end
      n_checks++; if (dc1 !== 34) begin n_fail++; $display("FAIL b2b_mul_done: got cycle %0d expected 34", dc1); end
      n_checks++; if (res2 !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL b2b_div_result: got %h expected %h", res2, 32'hFFFF_FFF2); end
      n_checks++; if (dc2 + 35 !== 69) begin n_fail++; $display("FAIL b2b_div_done: got cycle %0d expected 69", dc2 + 35); end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_mul_timing();
      test_directed();
      test_flush();
      test_random();
      test_back_to_back_after_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
